// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned STAT_WIDTH = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Circular first-set-bit search starting at a priority pointer.
// Produces a one-hot pick and a valid flag; purely combinational.
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  // Walk offsets 0..N_REQ-1 from ptr; the first requesting slot wins.
  // The inner loop matches slot i against (ptr+k) mod N_REQ, relying on ptr < N_REQ.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!valid && req[i] &&
            ((32'(ptr) + k == i) || (32'(ptr) + k == i + N_REQ))) begin
          gnt[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ producers.
// A grant lasts up to BURST_LEN accepted words; ownership rotates after each burst.
// Optional statistics counters are compiled in with FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [N_REQ-1:0]            ACK,
  output logic [N_REQ-1:0]            GNT,
  output logic                        BUSY,
  output logic                        FIFO_WR_CMD,
  output logic [DATA_WIDTH-1:0]       FIFO_WR_DATA,
  input  logic                        FIFO_FULL
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                        STAT_CLR,
  output logic [N_REQ*STAT_WIDTH-1:0] STAT_WORDS,
  output logic [STAT_WIDTH-1:0]       STAT_STALL
`endif
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0]      sel_gnt;
  logic                  sel_valid;
  logic [PTR_W-1:0]      owner_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  owner_req;
  logic [DATA_WIDTH-1:0] owner_data;

  rr_priority_select #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_sel (
    .req   (REQ),
    .ptr   (ptr_q),
    .gnt   (sel_gnt),
    .valid (sel_valid)
  );

  // Decode the registered one-hot owner into an index, its request and its data slice.
  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    owner_req = |(REQ & gnt_q);
    next_ptr  = (owner_idx == PTR_LAST) ? '0 : owner_idx + 1'b1;
  end

  // Write strobe, ack and data: only the owner, only when the FIFO has room, never in reset.
  always_comb begin
    ACK          = '0;
    FIFO_WR_CMD  = 1'b0;
    FIFO_WR_DATA = '0;
    if (state_q == BURST && !RESET && owner_req && !FIFO_FULL) begin
      ACK          = gnt_q;
      FIFO_WR_CMD  = 1'b1;
      FIFO_WR_DATA = owner_data;
    end
  end

  // Next-state logic: grant on request in IDLE; count, stall or release in BURST.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = BURST;
          gnt_d   = sel_gnt;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!owner_req || (!FIFO_FULL && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end else if (!FIFO_FULL) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = (state_q != IDLE);

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] words_q [N_REQ];
  logic [STAT_WIDTH-1:0] words_d [N_REQ];
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // Saturating per-requester word counts and owner stall cycles; clear beats increment.
  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (STAT_CLR) begin
      for (int unsigned i = 0; i < N_REQ; i++) words_d[i] = '0;
      stall_d = '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (ACK[i]) words_d[i] = sat_inc(words_q[i]);
      end
      if (state_q == BURST && owner_req && FIFO_FULL) stall_d = sat_inc(stall_q);
    end
  end

  // Statistics registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N_REQ; i++) words_q[i] <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    STAT_WORDS = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      STAT_WORDS[i*STAT_WIDTH +: STAT_WIDTH] = words_q[i];
    end
  end

  assign STAT_STALL = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 8;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    ACK;
  logic [N-1:0]    GNT;
  logic            BUSY;
  logic            FIFO_WR_CMD;
  logic [DW-1:0]   FIFO_WR_DATA;
  logic            FIFO_FULL;
`ifdef FIFO_ARB_STATS_EN
  logic            STAT_CLR;
  logic [N*32-1:0] STAT_WORDS;
  logic [31:0]     STAT_STALL;
`endif

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQ          (REQ),
    .REQ_DATA     (REQ_DATA),
    .ACK          (ACK),
    .GNT          (GNT),
    .BUSY         (BUSY),
    .FIFO_WR_CMD  (FIFO_WR_CMD),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_FULL    (FIFO_FULL)
`ifdef FIFO_ARB_STATS_EN
    ,
    .STAT_CLR     (STAT_CLR),
    .STAT_WORDS   (STAT_WORDS),
    .STAT_STALL   (STAT_STALL)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] rd [N];

  // Reference model: owner index (-1 = nobody), rotation pointer, words taken this burst.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int unsigned m_words [N];
  int unsigned m_stall;

  function automatic logic [N-1:0] exp_gnt_f();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] exp_ack_f();
    logic [N-1:0] a;
    a = '0;
    if (m_owner >= 0 && REQ[m_owner] && !FIFO_FULL && !RESET) a[m_owner] = 1'b1;
    return a;
  endfunction

  task automatic model_update();
    logic [N-1:0] a;
    bit found;
    int c;
    a = exp_ack_f();
`ifdef FIFO_ARB_STATS_EN
    if (RESET || STAT_CLR) begin
      for (int i = 0; i < N; i++) m_words[i] = 0;
      m_stall = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (a[i] && m_words[i] != 32'hFFFF_FFFF) m_words[i] = m_words[i] + 1;
      if (m_owner >= 0 && REQ[m_owner] && FIFO_FULL && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 1;
    end
`endif
    if (RESET) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && REQ[c]) begin
          found = 1; m_owner = c; m_cnt = 0;
        end
      end
    end else if (!REQ[m_owner] || (!FIFO_FULL && m_cnt == BL - 1)) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else if (!FIFO_FULL) begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // Present requester data and wait to the sampling point mid-cycle.
  task automatic settle();
    for (int i = 0; i < N; i++) REQ_DATA[i*DW +: DW] = rd[i];
    @(negedge CLK);
  endtask

  // Advance the model with this cycle's inputs and move past the next active edge.
  task automatic cycle_end();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; REQ = '0; FIFO_FULL = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    STAT_CLR = 1'b0;
`endif
    settle();
    cycle_end();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ = '1; FIFO_FULL = 1'b0;
    for (int i = 0; i < N; i++) rd[i] = $urandom;
    settle();
    n_checks++; if (GNT !== '0) $display("FAIL rst_gnt got=%b want=0", GNT); else n_pass++;
    n_checks++; if (ACK !== '0) $display("FAIL rst_ack got=%b want=0", ACK); else n_pass++;
    n_checks++; if (FIFO_WR_CMD !== 1'b0) $display("FAIL rst_cmd got=%b want=0", FIFO_WR_CMD); else n_pass++;
    n_checks++; if (FIFO_WR_DATA !== '0) $display("FAIL rst_data got=%h want=0", FIFO_WR_DATA); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy got=%b want=0", BUSY); else n_pass++;
`ifdef FIFO_ARB_STATS_EN
    n_checks++; if (STAT_WORDS !== '0 || STAT_STALL !== '0) $display("FAIL rst_stats got=%h/%h want=0", STAT_WORDS, STAT_STALL); else n_pass++;
`endif
    cycle_end();
    RESET = 1'b0; REQ = '0;
    settle();
    n_checks++; if (GNT !== '0 || BUSY !== 1'b0) $display("FAIL rst_idle got gnt=%b busy=%b want 0/0", GNT, BUSY); else n_pass++;
    cycle_end();
  endtask

  task automatic test_single_requester();
    int w = 0;
    bit ec;
    logic [N-1:0] eg;
    for (int c = 0; c <= 12; c++) begin
      REQ = (c < 12) ? 4'b0001 : 4'b0000;
      rd[0] = 32'hA0 + 32'(w);
      settle();
      ec = (c >= 1 && c <= 8) || c == 10 || c == 11;
      eg = ((c >= 1 && c <= 8) || c >= 10) ? 4'b0001 : 4'b0000;
      n_checks++; if (GNT !== eg) $display("FAIL single_gnt c=%0d got=%b want=%b", c, GNT, eg); else n_pass++;
      n_checks++; if (FIFO_WR_CMD !== ec) $display("FAIL single_cmd c=%0d got=%b want=%b", c, FIFO_WR_CMD, ec); else n_pass++;
      n_checks++; if (ACK !== (ec ? 4'b0001 : 4'b0000)) $display("FAIL single_ack c=%0d got=%b want=%b", c, ACK, ec ? 4'b0001 : 4'b0000); else n_pass++;
      n_checks++; if (FIFO_WR_DATA !== (ec ? 32'hA0 + 32'(w) : 32'h0)) $display("FAIL single_data c=%0d got=%h want=%h", c, FIFO_WR_DATA, ec ? 32'hA0 + 32'(w) : 32'h0); else n_pass++;
      if (ec) w++;
      cycle_end();
    end
    settle();
    n_checks++; if (GNT !== '0 || BUSY !== 1'b0) $display("FAIL single_end got gnt=%b busy=%b want 0/0", GNT, BUSY); else n_pass++;
    cycle_end();
  endtask

  task automatic test_all_four();
    int k [N];
    int nw = 0;
    int p, o;
    logic [N-1:0] eg;
    logic [DW-1:0] ed;
    do_reset();
    for (int i = 0; i < N; i++) k[i] = 0;
    for (int c = 0; c <= 37; c++) begin
      REQ = '1;
      for (int i = 0; i < N; i++) rd[i] = 32'h100 * 32'(i) + 32'(k[i]);
      settle();
      p = c % 9; o = (c / 9) % N;
      eg = '0; if (p != 0) eg[o] = 1'b1;
      ed = (p != 0) ? rd[o] : '0;
      n_checks++; if (GNT !== eg) $display("FAIL all4_gnt c=%0d got=%b want=%b", c, GNT, eg); else n_pass++;
      n_checks++; if (ACK !== eg) $display("FAIL all4_ack c=%0d got=%b want=%b", c, ACK, eg); else n_pass++;
      n_checks++; if (FIFO_WR_DATA !== ed) $display("FAIL all4_data c=%0d got=%h want=%h", c, FIFO_WR_DATA, ed); else n_pass++;
      n_checks++; if (BUSY !== (p != 0)) $display("FAIL all4_busy c=%0d got=%b want=%b", c, BUSY, p != 0); else n_pass++;
      if (FIFO_WR_CMD === 1'b1) nw++;
      if (c == 35) begin
        n_checks++; if (nw != 32) $display("FAIL all4_count got=%0d want=32", nw); else n_pass++;
      end
      if (p != 0) k[o]++;
      cycle_end();
    end
    REQ = '0; settle(); cycle_end();
  endtask

  task automatic test_full_stall();
    int w = 0;
    bit ec;
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      REQ = (c < 14) ? 4'b0001 : 4'b0000;
      FIFO_FULL = (c >= 5 && c <= 9);
      rd[0] = 32'hF00 + 32'(w);
      settle();
      ec = (c >= 1 && c <= 4) || (c >= 10 && c <= 13);
      eg = (c >= 1 && c <= 13) ? 4'b0001 : 4'b0000;
      n_checks++; if (GNT !== eg) $display("FAIL full_gnt c=%0d got=%b want=%b", c, GNT, eg); else n_pass++;
      n_checks++; if (FIFO_WR_CMD !== ec) $display("FAIL full_cmd c=%0d got=%b want=%b", c, FIFO_WR_CMD, ec); else n_pass++;
      n_checks++; if (ACK !== (ec ? 4'b0001 : 4'b0000)) $display("FAIL full_ack c=%0d got=%b want=%b", c, ACK, ec ? 4'b0001 : 4'b0000); else n_pass++;
      n_checks++; if (FIFO_WR_DATA !== (ec ? 32'hF00 + 32'(w) : 32'h0)) $display("FAIL full_data c=%0d got=%h want=%h", c, FIFO_WR_DATA, ec ? 32'hF00 + 32'(w) : 32'h0); else n_pass++;
      if (ec) w++;
      cycle_end();
    end
    FIFO_FULL = 1'b0;
    settle();
`ifdef FIFO_ARB_STATS_EN
    n_checks++; if (STAT_STALL !== 32'd5) $display("FAIL full_stat_stall got=%0d want=5", STAT_STALL); else n_pass++;
    n_checks++; if (STAT_WORDS[31:0] !== 32'd8) $display("FAIL full_stat_words got=%0d want=8", STAT_WORDS[31:0]); else n_pass++;
`endif
    n_checks++; if (BUSY !== 1'b0) $display("FAIL full_end_busy got=%b want=0", BUSY); else n_pass++;
    cycle_end();
  endtask

  task automatic test_owner_drop();
    int w = 0;
    logic [N-1:0] eg, ea;
    do_reset();
    rd[2] = 32'hE0;
    for (int c = 0; c <= 6; c++) begin
      REQ = (c < 3) ? 4'b0101 : (c < 6) ? 4'b0100 : 4'b0000;
      rd[0] = 32'hD0 + 32'(w);
      settle();
      eg = (c >= 1 && c <= 3) ? 4'b0001 : (c >= 5) ? 4'b0100 : 4'b0000;
      ea = (c == 1 || c == 2) ? 4'b0001 : (c == 5) ? 4'b0100 : 4'b0000;
      n_checks++; if (GNT !== eg) $display("FAIL drop_gnt c=%0d got=%b want=%b", c, GNT, eg); else n_pass++;
      n_checks++; if (ACK !== ea) $display("FAIL drop_ack c=%0d got=%b want=%b", c, ACK, ea); else n_pass++;
      n_checks++; if (FIFO_WR_CMD !== (ea != 0)) $display("FAIL drop_cmd c=%0d got=%b want=%b", c, FIFO_WR_CMD, ea != 0); else n_pass++;
      if (c == 5) begin
        n_checks++; if (FIFO_WR_DATA !== 32'hE0) $display("FAIL drop_data got=%h want=000000e0", FIFO_WR_DATA); else n_pass++;
      end
      if (ea[0]) w++;
      cycle_end();
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    logic [N-1:0] eg, ea;
    do_reset();
    rd[0] = 32'hC0;
    for (int c = 0; c <= 9; c++) begin
      REQ = (c < 6) ? 4'b0010 : (c < 9) ? 4'b0011 : 4'b0000;
      RESET = (c == 6);
      rd[1] = 32'hB0 + 32'(w);
      settle();
      eg = (c >= 1 && c <= 6) ? 4'b0010 : (c >= 8) ? 4'b0001 : 4'b0000;
      ea = (c >= 1 && c <= 5) ? 4'b0010 : (c == 8) ? 4'b0001 : 4'b0000;
      n_checks++; if (GNT !== eg) $display("FAIL rmid_gnt c=%0d got=%b want=%b", c, GNT, eg); else n_pass++;
      n_checks++; if (ACK !== ea) $display("FAIL rmid_ack c=%0d got=%b want=%b", c, ACK, ea); else n_pass++;
      n_checks++; if (FIFO_WR_CMD !== (ea != 0)) $display("FAIL rmid_cmd c=%0d got=%b want=%b", c, FIFO_WR_CMD, ea != 0); else n_pass++;
      n_checks++; if (FIFO_WR_DATA !== ((c == 8) ? 32'hC0 : (ea != 0) ? 32'hB0 + 32'(w) : 32'h0)) $display("FAIL rmid_data c=%0d got=%h", c, FIFO_WR_DATA); else n_pass++;
      if (c == 7) begin
        n_checks++; if (BUSY !== 1'b0) $display("FAIL rmid_busy got=%b want=0", BUSY); else n_pass++;
`ifdef FIFO_ARB_STATS_EN
        n_checks++; if (STAT_WORDS !== '0 || STAT_STALL !== '0) $display("FAIL rmid_stats got=%h/%h want=0", STAT_WORDS, STAT_STALL); else n_pass++;
`endif
      end
      if (ea[1]) w++;
      cycle_end();
    end
    RESET = 1'b0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    logic [N*32-1:0] ev;
    bit ec;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      REQ = (c < 27) ? 4'b0010 : 4'b0000;
      rd[1] = $urandom;
      settle();
      ec = (c < 27) && (c % 9 != 0);
      n_checks++; if (FIFO_WR_CMD !== ec) $display("FAIL stats_cmd c=%0d got=%b want=%b", c, FIFO_WR_CMD, ec); else n_pass++;
      cycle_end();
    end
    settle();
    ev = '0; ev[32 +: 32] = 32'd24;
    n_checks++; if (STAT_WORDS !== ev) $display("FAIL stats_words24 got=%h want=%h", STAT_WORDS, ev); else n_pass++;
    cycle_end();
    for (int c = 0; c <= 3; c++) begin
      REQ = (c < 3) ? 4'b0010 : 4'b0000;
      STAT_CLR = (c == 1);
      settle();
      if (c == 1) begin
        n_checks++; if (ACK !== 4'b0010) $display("FAIL stats_clr_ack got=%b want=0010", ACK); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (STAT_WORDS !== '0) $display("FAIL stats_clr got=%h want=0", STAT_WORDS); else n_pass++;
      end
      cycle_end();
    end
    STAT_CLR = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] pending, eg, ea;
    logic [DW-1:0] ed;
`ifdef FIFO_ARB_STATS_EN
    logic [N*32-1:0] ev;
`endif
    do_reset();
    pending = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          rd[i] = $urandom;
        end
      end
      REQ = pending;
      FIFO_FULL = ($urandom_range(0, 3) == 0);
      RESET = ($urandom_range(0, 149) == 0);
`ifdef FIFO_ARB_STATS_EN
      STAT_CLR = ($urandom_range(0, 59) == 0);
`endif
      settle();
      eg = exp_gnt_f();
      ea = exp_ack_f();
      ed = (ea != 0) ? rd[m_owner] : '0;
      n_checks++; if (GNT !== eg) $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, GNT, eg); else n_pass++;
      n_checks++; if (ACK !== ea) $display("FAIL rnd_ack c=%0d got=%b want=%b", c, ACK, ea); else n_pass++;
      n_checks++; if (FIFO_WR_CMD !== (ea != 0)) $display("FAIL rnd_cmd c=%0d got=%b want=%b", c, FIFO_WR_CMD, ea != 0); else n_pass++;
      n_checks++; if (FIFO_WR_DATA !== ed) $display("FAIL rnd_data c=%0d got=%h want=%h", c, FIFO_WR_DATA, ed); else n_pass++;
      n_checks++; if (BUSY !== (m_owner >= 0)) $display("FAIL rnd_busy c=%0d got=%b want=%b", c, BUSY, m_owner >= 0); else n_pass++;
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) ev[i*32 +: 32] = m_words[i];
      n_checks++; if (STAT_WORDS !== ev) $display("FAIL rnd_words c=%0d got=%h want=%h", c, STAT_WORDS, ev); else n_pass++;
      n_checks++; if (STAT_STALL !== m_stall) $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, STAT_STALL, m_stall); else n_pass++;
`endif
      pending = pending & ~ea;
      cycle_end();
    end
    RESET = 1'b0;
    FIFO_FULL = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    STAT_CLR = 1'b0;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; REQ = '0; FIFO_FULL = 1'b0; REQ_DATA = '0;
`ifdef FIFO_ARB_STATS_EN
    STAT_CLR = 1'b0;
`endif
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0;
    for (int i = 0; i < N; i++) begin
      m_words[i] = 0;
      rd[i] = '0;
    end
    test_reset();
    test_single_requester();
    test_all_four();
    test_full_stall();
    test_owner_drop();
    test_reset_mid();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous register FIFO among `N_REQ` producers in the mlp_conv datapath. Each producer presents words with a request/acknowledge handshake. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` words and drives the FIFO write interface, stalling on FIFO full. Grant rotates after every burst, so no producer starves.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: word width; must match the FIFO width.
- `BURST_LEN`, 8: maximum words per grant, ≥1.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `REQ`  in  `N_REQ`  bit i: requester i has a word on its data slice.
- `REQ_DATA`  in  `N_REQ*DATA_WIDTH`  requester i word at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ACK`  out  `N_REQ`  bit i: requester i's word was written this cycle. At most one bit set.
- `GNT`  out  `N_REQ`  registered one-hot current owner, or zero.
- `BUSY`  out  1  state is not IDLE.
- `FIFO_WR_CMD`  out  1  FIFO write strobe.
- `FIFO_WR_DATA`  out  `DATA_WIDTH`  FIFO write data.
- `FIFO_FULL`  in  1  FIFO full flag.

## Operation
- States: IDLE and BURST. State, `GNT`, priority pointer `ptr` and burst counter `cnt` (width `$clog2(BURST_LEN)`, min 1) are registered.
- **Requester rule.** Once `REQ[i]` is raised, requester i holds `REQ[i]` and its data slice stable until `ACK[i]`. Lowering `REQ[i]` while owner ends the burst.
- **IDLE.**
  - If `REQ` is nonzero, select the first set bit at or after `ptr`, searching circularly.
  - Next cycle: `GNT` = that one-hot, `cnt` = 0, state = BURST.
  - If `REQ` is zero, remain in IDLE.
- **BURST**, owner g:
  - `FIFO_WR_CMD` = `ACK[g]` = `REQ[g] & ~FIFO_FULL`.
  - `FIFO_WR_DATA` = slice g.
  - Accepted word with `cnt` < `BURST_LEN-1`: `cnt` + 1, stay in BURST.
  - Accepted word with `cnt` == `BURST_LEN-1`: release.
  - `REQ[g]` == 0: release the same cycle with no write.
  - `REQ[g]` == 1 and `FIFO_FULL` == 1: stall. `cnt` and `GNT` hold. No timeout.
- **Release.** Next cycle: state = IDLE, `GNT` = 0, `ptr` = (g+1) mod `N_REQ`, wrapping from `N_REQ-1` to 0.
- `FIFO_WR_DATA` is 0 whenever `FIFO_WR_CMD` is 0.
- Requests from non-owners are ignored during BURST. Their `ACK` stays 0.

## Timing
- **Reset values:** state IDLE, `GNT` 0, `ptr` 0, `cnt` 0, `ACK` 0, `FIFO_WR_CMD` 0, `FIFO_WR_DATA` 0, `BUSY` 0. With stats compiled in, all counters are 0.
- `ACK` and `FIFO_WR_CMD` are combinational from registered `GNT`, `REQ` and `FIFO_FULL`. Both are forced to 0 during any cycle with `RESET` high.
- **Reset mid-burst:** the burst aborts, nothing is written in the reset cycle, and the requester must re-request.
- **Latency:** `REQ` sampled in IDLE at cycle t → `GNT` at t+1 → first `ACK` no earlier than t+1.
- **Throughput:** 1 word/cycle within a burst. Each handover costs exactly one IDLE bubble cycle, so under contention the rate is `BURST_LEN` words per `BURST_LEN+1` cycles.
- **Full/empty interaction:** the arbiter never asserts `FIFO_WR_CMD` while `FIFO_FULL` is 1. It has no read-side visibility.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds input `STAT_CLR` (1 bit, synchronous clear).
  - Adds output `STAT_WORDS` (`N_REQ*32`): per-requester accepted-word counters.
  - Adds output `STAT_STALL` (32): cycles in BURST with `REQ[g]` & `FIFO_FULL`.
  - Counters saturate at all-ones.
  - `STAT_CLR` takes priority over an increment in the same cycle.
- `FIFO_ARB_STATS_EN` undefined: the ports and counters are absent, and arbitration behaviour is identical.

## Structure
- Shared package `fifo_arb_pkg` holds:
  - state enum `arb_state_t` (IDLE, BURST);
  - the stats counter width constant `STAT_WIDTH` = 32.
- Sub-module `rr_priority_select`: combinational, inputs `REQ` and `ptr`, outputs one-hot grant and a valid flag. It is instantiated once.

## Test plan
- **Single requester, FIFO never full:** `N_REQ`=4, `BURST_LEN`=8, `REQ`=0001 held for 10 words 0xA0..0xA9.
  - `GNT` one cycle after `REQ`.
  - 0xA0..0xA7 written on consecutive cycles, then one IDLE cycle.
  - 0xA8..0xA9 written after re-grant to requester 0 (`ptr` wrapped through 1..3).
- **All four requesting continuously:** grant order 0,1,2,3,0. Each burst is 8 writes, with one bubble between bursts, so 32 writes complete in 36 cycles.
- **`FIFO_FULL` high for 5 cycles mid-burst after word 3:** no `FIFO_WR_CMD` and no `ACK`, `cnt` holds. Words 4..7 follow when full drops. `STAT_STALL` = 5 with stats enabled.
- **Owner drops `REQ` after 2 words, requester 2 waiting:** release the same cycle, `GNT` = 0100 two cycles after the drop.
- **`RESET` asserted mid-burst at word 5:** no write in the reset cycle, and all outputs and stats reach their reset values the next cycle. Grant restarts from requester 0.
- **Stats:** three bursts of 8 from requester 1 give `STAT_WORDS[1]` = 24. `STAT_CLR` coincident with an accepted word gives 0.
